// File: rtl/seq_reduce_pkg.sv
// Shared encodings for the sequential reduction engine: operation modes and FSM states.
package seq_reduce_pkg;

    localparam logic [1:0] MODE_SUM = 2'b00;
    localparam logic [1:0] MODE_MAX = 2'b01;
    localparam logic [1:0] MODE_MIN = 2'b10;
    localparam logic [1:0] MODE_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/reduce_alu.sv
// Combinational fold step: combines accumulator a with channel b under the selected mode.
module reduce_alu
    import seq_reduce_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_y,
    output logic             o_carry
);

    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};

    // Ties in max/min keep the accumulator (a).
    always_comb begin
        o_y     = i_a;
        o_carry = 1'b0;
        case (i_mode)
            MODE_SUM: begin
                o_y     = w_sum[WIDTH-1:0];
                o_carry = w_sum[WIDTH];
            end
            MODE_MAX: if (i_b > i_a) o_y = i_b;
            MODE_MIN: if (i_b < i_a) o_y = i_b;
            default:  o_y = i_a ^ i_b;
        endcase
    end

endmodule

// File: rtl/seq_reduce_unit.sv
// Multi-cycle reduction of N channels into one WIDTH-bit result with a start/done handshake.
module seq_reduce_unit
    import seq_reduce_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [1:0]         i_mode,
    input  logic [N*WIDTH-1:0] i_data_in,
    output logic [WIDTH-1:0]   o_result,
    output logic               o_done,
    output logic               o_busy,
    output logic               o_ovf
);

    localparam int IDX_W = $clog2(N);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_ops [N];
    logic [1:0]         r_mode;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_ch;
    logic [WIDTH-1:0]   w_y;
    logic               w_carry;
    logic               w_last;
    logic               w_launch;

    assign w_ch     = r_ops[r_idx];
    assign w_last   = (r_idx == IDX_W'(N - 1));
    assign w_launch = (r_state == ST_IDLE) && i_start;

    reduce_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a     (r_acc),
        .i_b     (w_ch),
        .i_mode  (r_mode),
        .o_y     (w_y),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
            ST_RUN: begin
                o_busy = 1'b1;
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Channel 0 seeds the accumulator; the fold walks channels 1..N-1, one per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) r_ops[k] <= '0;
            r_mode   <= MODE_SUM;
            r_acc    <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else if (w_launch) begin
            for (int k = 0; k < N; k++) r_ops[k] <= i_data_in[k*WIDTH +: WIDTH];
            r_mode  <= i_mode;
            r_acc   <= i_data_in[WIDTH-1:0];
            r_idx   <= IDX_W'(1);
            r_carry <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_acc   <= w_y;
            r_idx   <= r_idx + 1'b1;
            r_carry <= r_carry | w_carry;
            if (w_last) begin
                r_result <= w_y;
                r_ovf    <= r_carry | w_carry;
            end
        end
    end

    assign o_result = r_result;
    assign o_ovf    = r_ovf;

endmodule

// File: tb/tb_seq_reduce_unit.sv
// Randomized bench for seq_reduce_unit at N=8/WIDTH=32 and N=2/WIDTH=8 against an arithmetic model.
module tb_seq_reduce_unit;

    localparam int W1 = 32;
    localparam int N1 = 8;
    localparam int W2 = 8;
    localparam int N2 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              s1 = 1'b0;
    logic [1:0]        m1 = 2'b00;
    logic [N1*W1-1:0]  d1 = '0;
    logic [W1-1:0]     r1;
    logic              dn1, b1, o1;

    logic              s2 = 1'b0;
    logic [1:0]        m2 = 2'b00;
    logic [N2*W2-1:0]  d2 = '0;
    logic [W2-1:0]     r2;
    logic              dn2, b2, o2;

    int n_vec = 0;
    int n_err = 0;
    longint unsigned exp_r1 = 0;
    bit              exp_o1 = 1'b0;

    seq_reduce_unit #(.WIDTH(W1), .N(N1)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_start(s1), .i_mode(m1), .i_data_in(d1),
        .o_result(r1), .o_done(dn1), .o_busy(b1), .o_ovf(o1)
    );

    seq_reduce_unit #(.WIDTH(W2), .N(N2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_start(s2), .i_mode(m2), .i_data_in(d2),
        .o_result(r2), .o_done(dn2), .o_busy(b2), .o_ovf(o2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Sequential partial sums are monotonic, so "any add carried" equals "total >= 2^w".
    function automatic void ref_model(input int w, input logic [1:0] m,
                                      input longint unsigned ch[$],
                                      output longint unsigned res, output bit ovf);
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned acc  = ch[0];
        ovf = 1'b0;
        if (m == 2'b00) begin
            for (int k = 1; k < ch.size(); k++) acc += ch[k];
            ovf = (acc > mask);
        end else begin
            for (int k = 1; k < ch.size(); k++) begin
                case (m)
                    2'b01:   if (ch[k] > acc) acc = ch[k];
                    2'b10:   if (ch[k] < acc) acc = ch[k];
                    default: acc = acc ^ ch[k];
                endcase
            end
        end
        res = acc & mask;
    endfunction

    task automatic load1(input longint unsigned v[8]);
        for (int k = 0; k < N1; k++) d1[k*W1 +: W1] = v[k][W1-1:0];
    endtask

    // One operation on the 8x32 instance; checks timing of busy/done and the final result.
    task automatic run1(input logic [1:0] m, input bit disturb, input bit hold);
        longint unsigned q[$];
        longint unsigned res;
        bit ovf;
        for (int k = 0; k < N1; k++) q.push_back(longint'(d1[k*W1 +: W1]));
        ref_model(W1, m, q, res, ovf);
        @(negedge clk);
        s1 = 1'b1;
        m1 = m;
        @(posedge clk);
        @(negedge clk);
        if (!hold) s1 = 1'b0;
        check("busy_e0", b1, 1'b1);
        check("held_result", r1, exp_r1);
        check("held_ovf", o1, exp_o1);
        for (int k = 1; k < N1; k++) begin
            if (disturb && k == 2) begin
                s1 = 1'b1;
                d1 = '0;
                m1 = ~m;
            end
            if (disturb && k == 3) s1 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (k < N1 - 1) begin
                check("busy_run", b1, 1'b1);
                check("done_early", dn1, 1'b0);
            end else begin
                check("done_pulse", dn1, 1'b1);
                check("busy_done", b1, 1'b0);
                check("result", r1, res);
                check("ovf", o1, ovf);
            end
        end
        exp_r1 = res;
        exp_o1 = ovf;
        @(posedge clk);
        @(negedge clk);
        check("done_end", dn1, 1'b0);
        check("busy_idle", b1, 1'b0);
        if (hold) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_restart", b1, 1'b1);
            s1 = 1'b0;
            for (int k = 0; k < N1; k++) begin
                @(posedge clk);
                @(negedge clk);
            end
            check("hold_idle", b1, 1'b0);
            for (int k = 0; k < N1; k++) q[k] = longint'(d1[k*W1 +: W1]);
            ref_model(W1, m, q, res, ovf);
            check("hold_result", r1, res);
            exp_r1 = res;
            exp_o1 = ovf;
        end
    endtask

    task automatic run2(input logic [1:0] m);
        longint unsigned q[$];
        longint unsigned res;
        bit ovf;
        for (int k = 0; k < N2; k++) q.push_back(longint'(d2[k*W2 +: W2]));
        ref_model(W2, m, q, res, ovf);
        @(negedge clk);
        s2 = 1'b1;
        m2 = m;
        @(posedge clk);
        @(negedge clk);
        s2 = 1'b0;
        check("n2_busy", b2, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("n2_done", dn2, 1'b1);
        check("n2_result", r2, res);
        check("n2_ovf", o2, ovf);
        @(posedge clk);
        @(negedge clk);
        check("n2_done_end", dn2, 1'b0);
    endtask

    longint unsigned dir[8] = '{1, 2, 1, 1, 3, 0, 1, 1};
    longint unsigned ones[8] = '{1, 1, 1, 1, 1, 1, 1, 1};
    longint unsigned maxv[8];
    longint unsigned rv[8];

    initial begin
        for (int k = 0; k < 8; k++) maxv[k] = 64'hFFFF_FFFF;
        #12;
        check("rst_result", r1, 0);
        check("rst_done", dn1, 0);
        check("rst_busy", b1, 0);
        check("rst_ovf", o1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        load1(dir);
        run1(2'b00, 1'b0, 1'b0);
        check("dir_sum", r1, 10);
        for (int mm = 1; mm < 4; mm++) run1(2'(mm), 1'b0, 1'b0);

        load1(maxv);
        run1(2'b00, 1'b0, 1'b0);
        check("sat_sum", r1, 64'hFFFF_FFF8);
        check("sat_ovf", o1, 1);
        load1(ones);
        run1(2'b00, 1'b0, 1'b0);
        check("ones_sum", r1, 8);

        load1(dir);
        run1(2'b00, 1'b1, 1'b0);
        check("disturb_sum", r1, 10);

        load1(ones);
        run1(2'b00, 1'b0, 1'b1);

        // Asynchronous reset three edges into a run.
        load1(maxv);
        @(negedge clk);
        s1 = 1'b1;
        m1 = 2'b00;
        @(posedge clk);
        @(negedge clk);
        s1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_result", r1, 0);
        check("arst_done", dn1, 0);
        check("arst_busy", b1, 0);
        check("arst_ovf", o1, 0);
        exp_r1 = 0;
        exp_o1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        load1(dir);
        run1(2'b01, 1'b0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < 8; k++)
                rv[k] = $urandom_range(0, 1) ? longint'($urandom) : longint'($urandom_range(0, 15));
            load1(rv);
            run1(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end

        d2 = {8'h90, 8'h80};
        run2(2'b00);
        check("n2_sum", r2, 8'h10);
        check("n2_sum_ovf", o2, 1);
        run2(2'b10);
        check("n2_min", r2, 8'h80);
        for (int t = 0; t < 20; t++) begin
            d2 = 16'($urandom);
            run2(2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_reduce_unit.md
Name: seq_reduce_unit

Overview:
- Parametrised multi-cycle reduction engine that folds N input channels of WIDTH bits into a single result.
- Operation is selected by a runtime mode: sum, unsigned max, unsigned min, or bitwise XOR.
- Uses the same start/done handshake style as the existing 8-input compute tops.
- Sits behind the top-level datapath; N, WIDTH and mode are decided at integration instead of being hard-wired to 8×32.

Parameters:
- WIDTH, 32, bit width of each channel and of the result.
- N, 8, number of input channels; legal range is N ≥ 2.
- IDX_W, $clog2(N), derived localparam; width of the channel index counter. Not user-overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  2  00 = sum, 01 = unsigned max, 10 = unsigned min, 11 = XOR.
- data_in  input  N*WIDTH  packed channels; channel k is data_in[k*WIDTH +: WIDTH].
- result  output  WIDTH  reduction result, registered.
- done  output  1  one-cycle completion pulse.
- busy  output  1  high while an operation is in flight.
- ovf  output  1  sticky carry-out for sum mode; 0 in all other modes.

Behaviour:
- Reset (rst_n low, asynchronous)
  - State goes to IDLE.
  - result = 0, done = 0, busy = 0, ovf = 0.
  - Internal operand registers, accumulator and index are cleared.
  - Reset asserted mid-operation aborts that operation; no done pulse is issued for it.
- States
  - IDLE: busy = 0, done = 0.
    - start = 1 at a rising edge → go to RUN.
    - On that edge: capture all of data_in and mode into internal registers, set acc ← channel 0, idx ← 1, clear the internal carry flag.
  - RUN: busy = 1.
    - Each edge: acc ← op(acc, ch[idx]) and idx ← idx + 1.
    - In sum mode, the carry flag ORs in the carry-out of each add.
    - When idx == N-1, the edge performing the final op also loads result ← final value and ovf ← final carry flag, then goes to DONE.
  - DONE: done = 1, busy = 0, for exactly one cycle, then IDLE unconditionally.
- Latency
  - The edge that samples start is E0.
  - done is high from edge E(N-1) to edge E(N).
  - For N = 8, done rises 7 edges after E0. For N = 2, done rises on E1.
- Between operations: result and ovf hold their values until the next DONE entry. They are not cleared by a new start.
- Arithmetic rules
  - Sum is modulo 2^WIDTH; ovf = 1 if any partial add carried out of bit WIDTH-1.
  - max and min use unsigned compare; on ties the accumulator value is kept.
  - XOR is bitwise.
  - In modes 01, 10 and 11, ovf is 0.
- Boundary and ignore rules
  - start high while in RUN or DONE is ignored; no queueing.
  - start held high continuously starts a new operation on the first IDLE edge after DONE.
  - Changes to data_in or mode after E0 do not affect the operation in flight.
  - mode values are fully decoded; no illegal encodings exist.

Decomposition:
- Shared package seq_reduce_pkg holds:
  - mode localparams MODE_SUM, MODE_MAX, MODE_MIN, MODE_XOR (2 bits);
  - state encoding ST_IDLE, ST_RUN, ST_DONE (2 bits).
- One combinational sub-module, reduce_alu:
  - inputs: a[WIDTH], b[WIDTH], mode;
  - outputs: y[WIDTH], carry.
- seq_reduce_unit holds the FSM, index counter, operand capture registers and accumulator.

Test Plan:
- Sum, N = 8, WIDTH = 32: data = {1,2,1,1,3,0,1,1}, mode = 00, 1-cycle start → result = 10, ovf = 0. done pulses once, 7 edges after E0. busy is high for edges E1–E6.
- Same data, modes 01, 10 and 11 in turn → result = 3, then 0, then 0. ovf = 0 each time. result is held between runs.
- All channels 0xFFFFFFFF, mode = 00 → result = 0xFFFFFFF8, ovf = 1. A following sum of all-1 channels → result = 8, ovf = 0.
- start pulsed again during RUN, with data_in changed mid-run to all zeros → ignored; the first run still yields result = 10 with a single done pulse.
- rst_n driven low at E3 of a run → done, busy, result and ovf read 0 immediately (asynchronously). After release, a fresh start completes correctly.
- Parameter sweep N = 2, WIDTH = 8: data = {0x80, 0x90}, mode = 00 → result = 0x10, ovf = 1, done on E1. mode = 10 → result = 0x80.
